// File: rtl/spi_fsm.sv
// SPI slave with a 10-bit command/payload frame and an internal byte memory.
// It accepts write-address, write-data, read-address and read-data commands, and read data shifts out on MISO.
module spi_fsm #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  typedef logic [ADDR_SIZE-1:0] addr_t;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic        cmd9_q, cmd9_d;
  logic        done_q, done_d;
  addr_t       wr_addr_q, wr_addr_d;
  addr_t       rd_addr_q, rd_addr_d;
  logic        flag_q, flag_d;
  logic [7:0]  tx_q, tx_d;
  logic [3:0]  txcnt_q, txcnt_d;
  logic        miso_q, miso_d;

  logic        mem_we;
  logic [7:0]  payload;
  logic [1:0]  cmd;
  logic [7:0]  mem [MEM_DEPTH];

  // On the final data edge, sh_q holds F[8:1] and MOSI carries F[0].
  assign payload = {sh_q[6:0], MOSI};
  assign cmd     = {cmd9_q, sh_q[7]};
  assign MISO    = miso_q;

  always_ff @(posedge clk) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q     <= '0;
      sh_q      <= '0;
      cmd9_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      flag_q    <= 1'b0;
      tx_q      <= '0;
      txcnt_q   <= '0;
      miso_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      cmd9_q    <= cmd9_d;
      done_q    <= done_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      flag_q    <= flag_d;
      tx_q      <= tx_d;
      txcnt_q   <= txcnt_d;
      miso_q    <= miso_d;
    end
  end

  // Memory is deliberately left out of reset so its contents survive it.
  always_ff @(posedge clk) begin
    if (mem_we && !rst_n) mem[wr_addr_q] <= payload;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    cmd9_d    = cmd9_q;
    done_d    = done_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    flag_d    = flag_q;
    tx_d      = tx_q;
    txcnt_d   = txcnt_q;
    miso_d    = 1'b0;
    mem_we    = 1'b0;

    // Read-data shift-out runs on its own counter, independent of frame bits.
    if (txcnt_q != 4'd0) begin
      miso_d  = tx_q[7];
      tx_d    = {tx_q[6:0], 1'b0};
      txcnt_d = txcnt_q - 4'd1;
    end

    if (SS_n) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      txcnt_d = '0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = CHK_CMD;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
        CHK_CMD: begin
          cmd9_d = MOSI;
          cnt_d  = '0;
          done_d = 1'b0;
          if (!MOSI)       state_d = WRITE;
          else if (flag_q) state_d = READ_DATA;
          else             state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (!done_q) begin
            sh_d = {sh_q[6:0], MOSI};
            if (cnt_q == 4'd8) begin
              done_d = 1'b1;
              cnt_d  = '0;
              // The action depends only on the two command bits, not on which state was entered.
              case (cmd)
                2'b00: wr_addr_d = ADDR_SIZE'(payload);
                2'b01: mem_we    = 1'b1;
                2'b10: begin
                  rd_addr_d = ADDR_SIZE'(payload);
                  flag_d    = 1'b1;
                end
                2'b11: begin
                  tx_d    = mem[rd_addr_q];
                  txcnt_d = 4'd8;
                  flag_d  = 1'b0;
                end
              endcase
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_fsm.sv
// Directed and randomized bench for spi_fsm.
// MISO is predicted from a frame-level model that tracks the memory and the two address registers.
module tb_spi_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic SS_n = 1'b1;
  logic MOSI = 1'b0;
  logic MISO;

  spi_fsm #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem_m [256];
  bit         known [256];
  logic [7:0] wr_m, rd_m;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic exp);
    tests++;
    assert (MISO === exp) else begin
      fails++;
      $error("FAIL %s: MISO=%b expected %b", tag, MISO, exp);
    end
  endtask

  task automatic model_reset();
    wr_m = 8'h00;
    rd_m = 8'h00;
  endtask

  // kind: 0 = complete frame, 1 = abort via SS_n after nbits, 2 = abort via reset after nbits
  task automatic frame(input string tag, input logic [9:0] f, input bit desel,
                       input int kind, input int nbits, input int extra);
    logic [7:0] d;
    bit         kn;
    bit         is_rd;
    if (desel) begin
      SS_n = 1'b1;
      MOSI = 1'($urandom);
      step();
      chk({tag, ":desel"}, 1'b0);
    end
    SS_n = 1'b0;
    MOSI = 1'b0;
    step();
    chk({tag, ":start"}, 1'b0);
    for (int i = 9; i >= 0; i--) begin
      if (kind != 0 && (9 - i) == nbits) break;
      MOSI = f[i];
      step();
      chk({tag, ":bit"}, 1'b0);
    end
    if (kind == 1) begin
      SS_n = 1'b1;
      step();
      chk({tag, ":ss_abort"}, 1'b0);
      return;
    end
    if (kind == 2) begin
      rst_n = 1'b1;
      step();
      chk({tag, ":rst_abort"}, 1'b0);
      rst_n = 1'b0;
      model_reset();
      return;
    end
    d = 8'h00;
    kn = 1'b1;
    is_rd = 1'b0;
    case (f[9:8])
      2'b00: wr_m = f[7:0];
      2'b01: begin
        mem_m[wr_m] = f[7:0];
        known[wr_m] = 1'b1;
      end
      2'b10: rd_m = f[7:0];
      2'b11: begin
        d = mem_m[rd_m];
        kn = known[rd_m];
        is_rd = 1'b1;
      end
    endcase
    for (int j = 0; j < extra; j++) begin
      MOSI = 1'($urandom);
      step();
      if (is_rd && j < 8) begin
        if (kn) chk({tag, ":miso_data"}, d[7-j]);
      end else begin
        chk({tag, ":tail"}, 1'b0);
      end
    end
  endtask

  initial begin
    logic [1:0] c;
    logic [7:0] p;
    int         r;
    int         kind;
    int         nb;

    for (int a = 0; a < 256; a++) known[a] = 1'b0;
    model_reset();

    rst_n = 1'b1;
    SS_n = 1'b1;
    step();
    step();
    chk("reset", 1'b0);

    // Reset with SS_n already low, then 11 cycles of MOSI=0 (write address 0x00)
    SS_n = 1'b0;
    step();
    chk("reset_ss_low", 1'b0);
    rst_n = 1'b0;
    model_reset();
    frame("wr_addr0", 10'b00_0000_0000, 1'b0, 0, 0, 2);
    frame("wr_data_aa", 10'b01_1010_1010, 1'b1, 0, 0, 3);
    frame("rd_addr0", 10'b10_0000_0000, 1'b1, 0, 0, 1);
    frame("rd_data_aa", 10'b11_0110_0101, 1'b1, 0, 0, 10);

    // Abort after 5 bits must leave mem[0] intact
    frame("abort5", 10'b01_0101_0101, 1'b1, 1, 5, 0);
    frame("after_abort_rd", 10'b11_0000_0000, 1'b1, 0, 0, 9);

    // Separate address registers: set write address and confirm read still hits 0x00
    frame("wr_addr_5a", 10'b00_0101_1010, 1'b1, 0, 0, 0);
    frame("wr_data_3c", 10'b01_0011_1100, 1'b1, 0, 0, 0);
    frame("rd_still0", 10'b11_1111_1111, 1'b1, 0, 0, 9);
    frame("rd_addr_5a", 10'b10_0101_1010, 1'b1, 0, 0, 0);
    frame("rd_5a", 10'b11_0000_0000, 1'b1, 0, 0, 9);

    // Reset during shift-out
    frame("rd_mid", 10'b11_0000_0000, 1'b1, 0, 0, 3);
    rst_n = 1'b1;
    step();
    chk("rst_mid_read", 1'b0);
    rst_n = 1'b0;
    model_reset();
    step();
    chk("post_rst", 1'b0);
    frame("rd_addr_0b", 10'b10_0000_0000, 1'b1, 0, 0, 0);
    frame("retained", 10'b11_0000_0000, 1'b1, 0, 0, 9);

    // Randomized frames over a small address window so reads hit written data
    for (int n = 0; n < 80; n++) begin
      c = 2'($urandom_range(3, 0));
      p = (c == 2'b00 || c == 2'b10) ? 8'($urandom_range(7, 0)) : 8'($urandom);
      r = $urandom_range(11, 0);
      kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      nb = $urandom_range(9, 0);
      frame("rand", {c, p}, 1'b1, kind, nb,
            (c == 2'b11) ? $urandom_range(10, 8) : $urandom_range(3, 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_fsm.md
SPI_FSM -- requirements
Module: spi_fsm

Interface
REQ-001 Parameter MEM_DEPTH, default 256: number of internal 8-bit memory words.
REQ-002 Parameter ADDR_SIZE, default 8: address width; MEM_DEPTH SHALL equal 2**ADDR_SIZE.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-high reset; 1 = reset, sampled on rising clk.
REQ-005 SS_n  input  1  slave select, active-low; 1 = deselected.
REQ-006 MOSI  input  1  serial data in, MSB first, sampled on rising clk.
REQ-007 MISO  output  1  serial data out, registered, MSB first.

Function
REQ-008 The block SHALL be an SPI slave FSM with an internal MEM_DEPTH x 8 memory, a write-address register, a read-address register and a read-address-valid flag.
REQ-009 States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-010 A frame is 10 bits, F[9:0], MSB first; F[9:8] is the command and F[7:0] is the payload.
REQ-011 IDLE: SS_n=0 -> CHK_CMD; otherwise stay in IDLE; MISO=0.
REQ-012 CHK_CMD: sample MOSI as F[9]; SS_n=1 -> IDLE; F[9]=0 -> WRITE; F[9]=1 and flag=0 -> READ_ADD; F[9]=1 and flag=1 -> READ_DATA.
REQ-013 WRITE/READ_ADD/READ_DATA: shift in F[8]..F[0] on 9 consecutive rising edges using a bit counter.
REQ-014 On the edge that captures F[0], the action SHALL be set by F[9:8] alone (00, 01, 10 or 11).
REQ-015 00: write-address <= F[7:0].
REQ-016 01: mem[write-address] <= F[7:0].
REQ-017 10: read-address <= F[7:0]; flag <= 1.
REQ-018 11: load mem[read-address] into an output shift register; flag <= 0.
REQ-019 After command 11, the next 8 rising edges SHALL drive MISO with data bits 7..0 in turn, while SS_n stays 0.
REQ-020 After those 8 bits, MISO SHALL return to 0.
REQ-021 After a completed command other than 11, the FSM SHALL stay in its state with MISO=0 and ignore further MOSI bits until SS_n=1.
REQ-022 SS_n=1 in any state SHALL move the FSM to IDLE on the next edge.
REQ-023 That abort SHALL discard a partial frame, clear the bit counter and force MISO=0.
REQ-024 An aborted frame SHALL leave the address registers, the flag and the memory unchanged.
REQ-025 Address wrap: addresses are ADDR_SIZE bits wide, so every F[7:0] value is a valid address; no out-of-range case exists.
REQ-026 A 0 -> 1 -> 0 pulse on SS_n lasting one cycle SHALL be sufficient to start a new frame.
REQ-027 The write path and the read path use separate address registers and do not affect each other.

Reset
REQ-028 While rst_n=1, on every rising edge: state=IDLE, MISO=0, bit counter=0, write-address=0, read-address=0, flag=0, output shift register=0.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no memory or address update.
REQ-031 After reset is released, if SS_n=0 the FSM SHALL enter CHK_CMD on the next edge.

Verification
REQ-032 Reset then write address: rst_n=1 for 1 cycle; SS_n=0; MOSI=0 for 11 cycles; SS_n=1 -> write-address=0x00, MISO=0 throughout.
REQ-033 Write data: frame 01_1010_1010 -> mem[0x00]=0xAA; MISO stays 0.
REQ-034 Read address: frame 10_0000_0000 -> read-address=0x00, flag=1; a subsequent frame starting with 1 enters READ_DATA.
REQ-035 Read data: frame 11_xxxx_xxxx, then 8 more cycles with SS_n=0 -> MISO = 1,0,1,0,1,0,1,0 on consecutive cycles, then 0; flag=0.
REQ-036 Abort: SS_n=1 after 5 bits of a frame 01_0101_0101 -> FSM in IDLE next cycle, mem[0x00] still 0xAA.
REQ-037 Reset mid-read: rst_n=1 during the MISO shift-out -> MISO=0 and state IDLE on the next edge; memory retained.
